// File: rtl/lo_iq_demod.sv
// rtl/lo_iq_demod.sv - 1-bit quadrature integrate-and-dump demodulator
//
// Mixes a 1-bit input stream with 1-bit sin/cos LO bits, integrates the +/-1
// products over 2^WIN_LOG2 enabled samples and dumps signed I/Q sums.
//
// Optional feature macro: LO_DEMOD_MAG_EN (adds registered |I|+|Q| stage).
//
// Ports:
//   clk        sample clock, rising edge
//   rstb       asynchronous active-low reset
//   sync_clr   synchronous clear of window counter, accumulators, sat_flag
//   en         sample enable; 0 holds all state
//   din        input bit to demodulate
//   lo_sin     LO in-phase bit
//   lo_cos     LO quadrature bit
//   i_out      signed I sum of last completed window
//   q_out      signed Q sum of last completed window
//   out_valid  one-cycle pulse when i_out/q_out update
//   sat_flag   sticky: an accumulator saturated since reset/sync_clr
//   mag_out    |i_out|+|q_out|, one clock after out_valid (0 without macro)

module lo_iq_demod #(
    parameter int ACC_W    = 16,
    parameter int WIN_LOG2 = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             sync_clr,
    input  logic             en,
    input  logic             din,
    input  logic             lo_sin,
    input  logic             lo_cos,
    output logic [ACC_W-1:0] i_out,
    output logic [ACC_W-1:0] q_out,
    output logic             out_valid,
    output logic             sat_flag,
    output logic [ACC_W:0]   mag_out
);

    // A window of one sample still needs a one-bit counter that never moves.
    localparam int CNT_W = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'((1 << WIN_LOG2) - 1);

    // Symmetric clamp limits: the most-negative code is never produced.
    localparam logic [ACC_W-1:0] POS_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] NEG_MAX = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0] ONE     = {{(ACC_W-1){1'b0}}, 1'b1};

    logic [ACC_W-1:0] i_acc;
    logic [ACC_W-1:0] q_acc;
    logic [CNT_W-1:0] win_cnt;

    logic             p_i_pos;
    logic             p_q_pos;
    logic             i_sat;
    logic             q_sat;
    logic [ACC_W-1:0] i_next;
    logic [ACC_W-1:0] q_next;
    logic             terminal;

    // Product of two +/-1 values encoded as bits is XNOR: equal bits -> +1.
    always_comb begin
        p_i_pos  = ~(din ^ lo_sin);
        p_q_pos  = ~(din ^ lo_cos);
        i_sat    = p_i_pos ? (i_acc == POS_MAX) : (i_acc == NEG_MAX);
        q_sat    = p_q_pos ? (q_acc == POS_MAX) : (q_acc == NEG_MAX);
        i_next   = i_sat ? i_acc : (p_i_pos ? i_acc + ONE : i_acc - ONE);
        q_next   = q_sat ? q_acc : (p_q_pos ? q_acc + ONE : q_acc - ONE);
        terminal = (win_cnt == CNT_TERM);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            i_acc     <= '0;
            q_acc     <= '0;
            win_cnt   <= '0;
            i_out     <= '0;
            q_out     <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (sync_clr) begin
                // Clear beats a coinciding terminal sample: no dump, outputs hold.
                i_acc    <= '0;
                q_acc    <= '0;
                win_cnt  <= '0;
                sat_flag <= 1'b0;
            end else if (en) begin
                if (i_sat || q_sat) begin
                    sat_flag <= 1'b1;
                end
                if (terminal) begin
                    // The terminal sample is folded into the dumped sums.
                    i_out     <= i_next;
                    q_out     <= q_next;
                    out_valid <= 1'b1;
                    i_acc     <= '0;
                    q_acc     <= '0;
                    win_cnt   <= '0;
                end else begin
                    i_acc   <= i_next;
                    q_acc   <= q_next;
                    win_cnt <= win_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef LO_DEMOD_MAG_EN
    logic [ACC_W-1:0] i_abs;
    logic [ACC_W-1:0] q_abs;

    // Symmetric clamp guarantees the negation never overflows.
    always_comb begin
        i_abs = i_out[ACC_W-1] ? (~i_out + ONE) : i_out;
        q_abs = q_out[ACC_W-1] ? (~q_out + ONE) : q_out;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            mag_out <= '0;
        end else if (out_valid) begin
            mag_out <= {1'b0, i_abs} + {1'b0, q_abs};
        end
    end
`else
    assign mag_out = '0;
`endif

endmodule

// File: tb/tb_lo_iq_demod.sv
// tb/tb_lo_iq_demod.sv - self-checking bench for lo_iq_demod

module tb_lo_iq_demod;

`ifdef LO_DEMOD_MAG_EN
    localparam bit MAG_ON = 1'b1;
`else
    localparam bit MAG_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstb = 1'b0;
    logic sync_clr = 1'b0;
    logic en_a = 1'b0;
    logic en_b = 1'b0;
    logic din = 1'b0;
    logic lo_sin = 1'b0;
    logic lo_cos = 1'b0;
    logic chk_on = 1'b0;

    logic [15:0] i_out_a, q_out_a;
    logic [16:0] mag_out_a;
    logic        out_valid_a, sat_flag_a;
    logic [5:0]  i_out_b, q_out_b;
    logic [6:0]  mag_out_b;
    logic        out_valid_b, sat_flag_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lo_iq_demod #(.ACC_W(16), .WIN_LOG2(8)) dut_a (
        .clk(clk), .rstb(rstb), .sync_clr(sync_clr), .en(en_a), .din(din),
        .lo_sin(lo_sin), .lo_cos(lo_cos), .i_out(i_out_a), .q_out(q_out_a),
        .out_valid(out_valid_a), .sat_flag(sat_flag_a), .mag_out(mag_out_a)
    );

    lo_iq_demod #(.ACC_W(6), .WIN_LOG2(6)) dut_b (
        .clk(clk), .rstb(rstb), .sync_clr(sync_clr), .en(en_b), .din(din),
        .lo_sin(lo_sin), .lo_cos(lo_cos), .i_out(i_out_b), .q_out(q_out_b),
        .out_valid(out_valid_b), .sat_flag(sat_flag_b), .mag_out(mag_out_b)
    );

    // Model state per instance: running sums, sample count, published results.
    int si [2] = '{0, 0};
    int sq [2] = '{0, 0};
    int cn [2] = '{0, 0};
    int ei [2] = '{0, 0};
    int eq [2] = '{0, 0};
    int ev [2] = '{0, 0};
    int es [2] = '{0, 0};
    int em [2] = '{0, 0};

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic mstep(input int k, input int aw, input int wl, input logic e);
        int lim;
        int pi;
        int pq;
        lim = (1 << (aw - 1)) - 1;
        if (ev[k] != 0) em[k] = iabs(ei[k]) + iabs(eq[k]);
        ev[k] = 0;
        if (sync_clr) begin
            si[k] = 0; sq[k] = 0; cn[k] = 0; es[k] = 0;
        end else if (e) begin
            pi = (din == lo_sin) ? 1 : -1;
            pq = (din == lo_cos) ? 1 : -1;
            si[k] += pi;
            sq[k] += pq;
            if (si[k] > lim) begin si[k] = lim; es[k] = 1; end
            if (si[k] < -lim) begin si[k] = -lim; es[k] = 1; end
            if (sq[k] > lim) begin sq[k] = lim; es[k] = 1; end
            if (sq[k] < -lim) begin sq[k] = -lim; es[k] = 1; end
            cn[k]++;
            if (cn[k] == (1 << wl)) begin
                ei[k] = si[k]; eq[k] = sq[k]; ev[k] = 1;
                si[k] = 0; sq[k] = 0; cn[k] = 0;
            end
        end
    endtask

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int k = 0; k < 2; k++) begin
                si[k] = 0; sq[k] = 0; cn[k] = 0; ei[k] = 0;
                eq[k] = 0; ev[k] = 0; es[k] = 0; em[k] = 0;
            end
        end else begin
            mstep(0, 16, 8, en_a);
            mstep(1, 6, 6, en_b);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("a.i_out", int'($signed(i_out_a)), ei[0]);
            chk("a.q_out", int'($signed(q_out_a)), eq[0]);
            chk("a.out_valid", int'(out_valid_a), ev[0]);
            chk("a.sat_flag", int'(sat_flag_a), es[0]);
            chk("a.mag_out", int'(mag_out_a), MAG_ON ? em[0] : 0);
            chk("b.i_out", int'($signed(i_out_b)), ei[1]);
            chk("b.q_out", int'($signed(q_out_b)), eq[1]);
            chk("b.out_valid", int'(out_valid_b), ev[1]);
            chk("b.sat_flag", int'(sat_flag_b), es[1]);
            chk("b.mag_out", int'(mag_out_b), MAG_ON ? em[1] : 0);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic lit_a(input string tag, input int vi, input int vq, input int vv, input int vs);
        chk({tag, ".i"}, int'($signed(i_out_a)), vi);
        chk({tag, ".q"}, int'($signed(q_out_a)), vq);
        chk({tag, ".valid"}, int'(out_valid_a), vv);
        chk({tag, ".sat"}, int'(sat_flag_a), vs);
    endtask

    task automatic lit_b(input string tag, input int vi, input int vq, input int vv, input int vs);
        chk({tag, ".i"}, int'($signed(i_out_b)), vi);
        chk({tag, ".q"}, int'($signed(q_out_b)), vq);
        chk({tag, ".valid"}, int'(out_valid_b), vv);
        chk({tag, ".sat"}, int'(sat_flag_b), vs);
    endtask

    initial begin
        repeat (2) step();
        lit_a("reset_a", 0, 0, 0, 0);
        lit_b("reset_b", 0, 0, 0, 0);
        chk("reset_a.mag", int'(mag_out_a), 0);
        rstb = 1'b1;
        chk_on = 1'b1;
        step();

        // Scenario 1: din=1, sin=1, cos=0 -> I=+256, Q=-256.
        din = 1'b1; lo_sin = 1'b1; lo_cos = 1'b0; en_a = 1'b1;
        repeat (255) step();
        chk("s1_early.valid", int'(out_valid_a), 0);
        step();
        lit_a("s1", 256, -256, 1, 0);
        en_a = 1'b0;
        step();
        chk("s1.valid_pulse", int'(out_valid_a), 0);
        chk("s1.mag", int'(mag_out_a), MAG_ON ? 512 : 0);

        // Scenario 2: din toggles, cos follows din -> I=0, Q=+256.
        en_a = 1'b1;
        for (int n = 0; n < 256; n++) begin
            din = ~din;
            lo_cos = din;
            step();
        end
        lit_a("s2", 0, 256, 1, 0);

        // Scenario 4: 10-cycle enable gap after 100 samples.
        din = 1'b1; lo_sin = 1'b1; lo_cos = 1'b1;
        repeat (100) step();
        en_a = 1'b0;
        repeat (10) step();
        en_a = 1'b1;
        repeat (155) step();
        chk("s4_early.valid", int'(out_valid_a), 0);
        step();
        lit_a("s4", 256, 256, 1, 0);

        // Scenario 5: reset at sample 128, full window after release.
        repeat (128) step();
        rstb = 1'b0;
        #1;
        lit_a("s5_rst", 0, 0, 0, 0);
        step();
        rstb = 1'b1;
        din = 1'b0; lo_sin = 1'b1; lo_cos = 1'b0;
        repeat (255) step();
        chk("s5_early.valid", int'(out_valid_a), 0);
        step();
        lit_a("s5", -256, 256, 1, 0);

        // Scenario 3 on the narrow instance: saturation and sticky flag.
        en_a = 1'b0; en_b = 1'b1;
        din = 1'b1; lo_sin = 1'b1; lo_cos = 1'b1;
        repeat (64) step();
        lit_b("s3_w1", 31, 31, 1, 1);
        repeat (64) step();
        lit_b("s3_w2", 31, 31, 1, 1);
        en_b = 1'b0; sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        lit_b("s3_clr", 31, 31, 0, 0);
        din = 1'b0; lo_sin = 1'b1; lo_cos = 1'b0; en_b = 1'b1;
        repeat (64) step();
        lit_b("s3_neg", -31, 31, 1, 1);
        chk("s3_neg.mag", int'(mag_out_b), 0);
        step();
        chk("s3_neg.mag_next", int'(mag_out_b), MAG_ON ? 62 : 0);

        // Clear coinciding with the terminal sample: no dump.
        en_b = 1'b0; en_a = 1'b1;
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        din = 1'b1; lo_sin = 1'b1; lo_cos = 1'b1;
        repeat (255) step();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        lit_a("clr_term", -256, 256, 0, 0);
        repeat (256) step();
        lit_a("after_clr", 256, 256, 1, 0);
        en_a = 1'b0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
